muldiv_unit: RTL and testbench

Iterative 32-bit multiply/divide unit for the MIPS datapath. It executes the MULT, MULTU, DIV and DIVU operations that the single-cycle ALU does not implement, and holds the results in architectural HI/LO registers. It sits beside the ALU and takes the same A/B operands (rs/rt). The control unit issues an operation with a start/ready handshake and stalls the pipeline until `done`.

---
 rtl/muldiv_pkg.sv | 22 ++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - op encodings, FSM states and constants shared by the multiply/divide unit
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } muldiv_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREP,
      ST_RUN,
      ST_FIX,
      ST_DONE
   } muldiv_state_e;

   localparam int          MULDIV_ITERS  = 32;
   localparam logic [31:0] MULDIV_DBZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO
// MULDIV_EARLY_OUT_EN: multiply leaves RUN once the remaining multiplier magnitude is zero.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic             div_by_zero
);

   muldiv_state_e      state_q, state_d;
   muldiv_op_e         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [5:0]         cnt_q, cnt_d;
   logic               neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               dbz_q, dbz_d;

   logic               is_signed, is_div;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     div_part;
   logic               div_ge;
   logic [WIDTH-1:0]   div_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   assign is_signed = op_q[0];
   assign is_div    = op_q[1];
   assign mag_a     = (is_signed && a_q[WIDTH-1]) ? (~a_q + 1'b1) : a_q;
   assign mag_b     = (is_signed && b_q[WIDTH-1]) ? (~b_q + 1'b1) : b_q;

   // Restoring step: partial remainder shifted left with the next dividend bit appended.
   assign div_part  = acc_q[2*WIDTH-1:WIDTH-1];
   assign div_ge    = div_part >= {1'b0, opnd_q[WIDTH-1:0]};
   assign div_sub   = div_part[WIDTH-1:0] - opnd_q[WIDTH-1:0];

   assign prod_fix  = neg_res_q ? (~acc_q + 1'b1) : acc_q;
   assign quo_fix   = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
   assign rem_fix   = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      dbz_d     = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = muldiv_op_e'(op);
               a_d     = A;
               b_d     = B;
               state_d = ST_PREP;
            end
         end
         ST_PREP: begin
            neg_res_d = is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            neg_rem_d = is_signed & a_q[WIDTH-1];
            cnt_d     = '0;
            mplier_d  = mag_b;
            if (is_div) begin
               acc_d  = {{WIDTH{1'b0}}, mag_a};
               opnd_d = {{WIDTH{1'b0}}, mag_b};
            end else begin
               acc_d  = '0;
               opnd_d = {{WIDTH{1'b0}}, mag_a};
            end
            state_d = ST_RUN;
         end
         ST_RUN: begin
            cnt_d = cnt_q + 6'd1;
            if (is_div) begin
               acc_d = div_ge ? {div_sub, acc_q[WIDTH-2:0], 1'b1}
                              : {div_part[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
               acc_d    = acc_q + (mplier_q[0] ? opnd_q : '0);
               opnd_d   = opnd_q << 1;
               mplier_d = mplier_q >> 1;
            end
            if (cnt_q == 6'(MULDIV_ITERS - 1)) state_d = ST_FIX;
`ifdef MULDIV_EARLY_OUT_EN
            if (!is_div && (mplier_d == '0)) state_d = ST_FIX;
`endif
         end
         ST_FIX: begin
            if (!is_div) begin
               hi_d  = prod_fix[2*WIDTH-1:WIDTH];
               lo_d  = prod_fix[WIDTH-1:0];
               dbz_d = 1'b0;
            end else if (b_q == '0) begin
               hi_d  = a_q;
               lo_d  = WIDTH'(MULDIV_DBZ_LO);
               dbz_d = 1'b1;
            end else begin
               hi_d  = rem_fix;
               lo_d  = quo_fix;
               dbz_d = 1'b0;
            end
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         op_q      <= OP_MULTU;
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         dbz_q     <= dbz_d;
      end
   end

   assign ready       = (state_q == ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign HI          = hi_q;
   assign LO          = lo_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed-vector bench for muldiv_unit with an arithmetic reference model
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
   localparam bit EO = 1'b1;
`else
   localparam bit EO = 1'b0;
`endif

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] A     = '0;
   logic [31:0] B     = '0;
   logic        ready, done, dbz;
   logic [31:0] HI, LO;

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;
   int c0          = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .ready(ready), .done(done), .HI(HI), .LO(LO), .div_by_zero(dbz)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference: plain 64-bit arithmetic, plus n = iterations the op takes.
   function automatic void model_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output logic z, output int n);
      logic [63:0] p;
      longint      sa, sb;
      logic [31:0] mag;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      z   = 1'b0;
      n   = 32;
      hi  = '0;
      lo  = '0;
      mag = b;
      case (o)
         2'b00: begin
            p  = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
         end
         2'b01: begin
            p   = 64'(sa * sb);
            hi  = p[63:32];
            lo  = p[31:0];
            mag = b[31] ? 32'(-sb) : b;
         end
         2'b10: begin
            if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; z = 1'b1; end
            else begin lo = a / b; hi = a % b; end
         end
         default: begin
            if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; z = 1'b1; end
            else begin
               p  = 64'(sa / sb);
               lo = p[31:0];
               p  = 64'(sa % sb);
               hi = p[31:0];
            end
         end
      endcase
      if (EO && !o[1]) begin
         n = 1;
         for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
      end
   endfunction

   bit          m_busy = 1'b0;
   int          m_k    = 0;
   int          m_n    = 32;
   logic [31:0] m_hi   = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_dbz  = 1'b0, p_dbz = 1'b0;

   always @(posedge clk or negedge reset) begin : model
      logic [31:0] h, l;
      logic        z;
      int          n;
      if (!reset) begin
         m_busy <= 1'b0;
         m_k    <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_dbz  <= 1'b0;
      end else if (m_busy) begin
         m_k <= m_k + 1;
         if (m_k + 1 == m_n + 2) begin
            m_hi  <= p_hi;
            m_lo  <= p_lo;
            m_dbz <= p_dbz;
         end
         if (m_k + 1 == m_n + 3) m_busy <= 1'b0;
      end else if (start) begin
         model_op(op, A, B, h, l, z, n);
         p_hi   <= h;
         p_lo   <= l;
         p_dbz  <= z;
         m_n    <= n;
         m_k    <= 0;
         m_busy <= 1'b1;
      end
   end

   always @(negedge clk) begin
      check("ready", 32'(ready), 32'(!m_busy));
      check("done", 32'(done), 32'(m_busy && (m_k == m_n + 2)));
      check("HI", HI, m_hi);
      check("LO", LO, m_lo);
      check("div_by_zero", 32'(dbz), 32'(m_dbz));
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
      A = $urandom; B = $urandom;
      c0 = cyc;
   endtask

   task automatic wait_done(input string name, output int lat);
      lat = -1;
      for (int i = 0; i < 200; i++) begin
         if (done) begin
            lat = cyc - c0;
            return;
         end
         @(negedge clk);
      end
      vectors++;
      miscompares++;
      $display("FAIL %s: done never seen, got timeout expected done", name);
   endtask

   task automatic run(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo, input logic edbz, input int elat);
      int lat;
      issue(o, a, b);
      wait_done(name, lat);
      check({name, " HI"}, HI, ehi);
      check({name, " LO"}, LO, elo);
      check({name, " dbz"}, 32'(dbz), 32'(edbz));
      check({name, " latency"}, 32'(lat), 32'(elat));
   endtask

   initial begin
      int lat, dcount;
      repeat (2) @(negedge clk);
      check("reset ready", 32'(ready), 32'd1);
      check("reset done", 32'(done), 32'd0);
      check("reset HI", HI, 32'd0);
      check("reset LO", LO, 32'd0);
      check("reset dbz", 32'(dbz), 32'd0);
      reset = 1'b1;

      run("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 34);
      run("mult_neg",  2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, EO ? 5 : 34);
      run("div_neg",   2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34);
      run("divu_zero", 2'b10, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 34);
      run("multu_2x3", 2'b00, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, EO ? 4 : 34);
      run("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 34);
      run("divu_100",  2'b10, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 34);
      run("div_negb",  2'b11, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 34);
      run("mult_min",  2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 34);
      run("mult_m1",   2'b01, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0, EO ? 5 : 34);
      run("div_zeroa", 2'b11, 32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 34);
      run("div_bzero", 2'b11, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 34);
      run("eo_b0",     2'b00, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0, EO ? 3 : 34);
      run("eo_b1",     2'b00, 32'hDEAD_BEEF, 32'd1,         32'd0,         32'hDEAD_BEEF, 1'b0, EO ? 3 : 34);
      run("eo_bmsb",   2'b00, 32'd3,         32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 34);

      // A start while busy must not disturb the operation in flight.
      issue(2'b00, 32'h10, 32'h20);
      repeat (4) @(negedge clk);
      start = 1'b1; op = 2'b10; A = 32'd5; B = 32'd0;
      @(negedge clk);
      start = 1'b0;
      wait_done("busy_start", lat);
      check("busy_start HI", HI, 32'd0);
      check("busy_start LO", LO, 32'h200);
      check("busy_start dbz", 32'(dbz), 32'd0);
      check("busy_start latency", 32'(lat), EO ? 32'd8 : 32'd34);

      // Reset asserted mid-operation aborts with no done pulse.
      issue(2'b10, 32'h1000, 32'd3);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("abort ready", 32'(ready), 32'd1);
      check("abort done", 32'(done), 32'd0);
      check("abort HI", HI, 32'd0);
      check("abort LO", LO, 32'd0);
      check("abort dbz", 32'(dbz), 32'd0);
      @(negedge clk);
      #1 reset = 1'b1;
      dcount = 0;
      repeat (50) begin
         @(negedge clk);
         if (done) dcount++;
      end
      check("abort no_done", 32'(dcount), 32'd0);

      run("after_abort", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, EO ? 5 : 34);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
